// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: shared types, widths and helpers for the pipeline
// hazard controller (FSM state encoding, control bundle, saturating counters).
package pipe_hazard_ctrl_pkg;

    // Controller FSM states
    typedef enum logic [1:0] {
        INIT     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2
    } state_e;

    // Architectural zero register: never a real producer, so never a hazard
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Counter widths
    localparam int INIT_CNT_W = 4;
    localparam int WAIT_CNT_W = 8;
    localparam int PERF_CNT_W = 32;

    localparam logic [WAIT_CNT_W-1:0] WAIT_CNT_MAX = 8'hFF;
    localparam logic [PERF_CNT_W-1:0] PERF_CNT_MAX = 32'hFFFF_FFFF;

    // One cycle's worth of pipeline-register controls
    typedef struct packed {
        logic pc_write;
        logic if_id_stall;
        logic if_id_flush;
        logic id_ex_flush;
        logic freeze;
    } ctrl_t;

    // Pipeline being cleared: PC held, both front registers zeroed
    localparam ctrl_t CTRL_RESET = '{pc_write: 1'b0, if_id_stall: 1'b0,
                                     if_id_flush: 1'b1, id_ex_flush: 1'b1,
                                     freeze: 1'b0};

    // Outstanding data-memory access: everything holds
    localparam ctrl_t CTRL_FREEZE = '{pc_write: 1'b0, if_id_stall: 1'b1,
                                      if_id_flush: 1'b0, id_ex_flush: 1'b0,
                                      freeze: 1'b1};

    // Normal-flow decision once no memory access is pending. A load-use
    // hazard wins over a taken branch because the branch operands in ID
    // are not yet valid; the branch is re-resolved after the bubble.
    function automatic ctrl_t run_ctrl(input logic hazard, input logic taken);
        ctrl_t c;
        c = '{pc_write: 1'b1, if_id_stall: 1'b0, if_id_flush: 1'b0,
              id_ex_flush: 1'b0, freeze: 1'b0};
        if (hazard) begin
            c.pc_write    = 1'b0;
            c.if_id_stall = 1'b1;
            c.id_ex_flush = 1'b1;
        end else if (taken) begin
            c.if_id_flush = 1'b1;
        end else begin
            c.pc_write    = 1'b1;
        end
        return c;
    endfunction

    // Wait counter increment, saturating at its maximum
    function automatic logic [WAIT_CNT_W-1:0] wait_inc(input logic [WAIT_CNT_W-1:0] cnt);
        logic [WAIT_CNT_W-1:0] r;
        if (cnt == WAIT_CNT_MAX) begin
            r = cnt;
        end else begin
            r = cnt + 8'd1;
        end
        return r;
    endfunction

    // Conditional performance counter increment, saturating at its maximum
    function automatic logic [PERF_CNT_W-1:0] perf_inc(input logic [PERF_CNT_W-1:0] cnt,
                                                       input logic en);
        logic [PERF_CNT_W-1:0] r;
        if (en && (cnt != PERF_CNT_MAX)) begin
            r = cnt + 32'd1;
        end else begin
            r = cnt;
        end
        return r;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: hazard sources from ID/EX/MEM and the resulting
// pipeline controls. master = pipeline datapath, slave = hazard controller.
interface pipe_hazard_ctrl_if;

    logic [4:0] ID_rs_i;
    logic [4:0] ID_rt_i;
    logic       EX_MemRead_i;
    logic [4:0] EX_rt_i;
    logic       ID_taken_i;
    logic       dmem_miss_i;
    logic       dmem_ack_i;

    logic       PC_write_o;
    logic       IF_ID_Stall_o;
    logic       IF_ID_Flush_o;
    logic       ID_EX_Flush_o;
    logic       Freeze_o;
    logic       err_o;

    modport master (
        output ID_rs_i, ID_rt_i, EX_MemRead_i, EX_rt_i, ID_taken_i,
               dmem_miss_i, dmem_ack_i,
        input  PC_write_o, IF_ID_Stall_o, IF_ID_Flush_o, ID_EX_Flush_o,
               Freeze_o, err_o
    );

    modport slave (
        input  ID_rs_i, ID_rt_i, EX_MemRead_i, EX_rt_i, ID_taken_i,
               dmem_miss_i, dmem_ack_i,
        output PC_write_o, IF_ID_Stall_o, IF_ID_Flush_o, ID_EX_Flush_o,
               Freeze_o, err_o
    );

endinterface

// File: rtl/pipe_hazard_ctrl_ldu.sv
// pipe_hazard_ctrl_ldu: combinational load-use comparator. Flags an
// instruction in ID that reads the register a load in EX is about to write.
module pipe_hazard_ctrl_ldu
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [4:0] id_rs_i,
    input  logic [4:0] id_rt_i,
    input  logic       ex_mem_read_i,
    input  logic [4:0] ex_rt_i,
    output logic       hazard_o
);

    logic rs_hit_s;
    logic rt_hit_s;

    // Compare the load destination against both ID source fields
    always_comb begin
        rs_hit_s = (ex_rt_i == id_rs_i);
        rt_hit_s = (ex_rt_i == id_rt_i);
        if (ex_mem_read_i && (ex_rt_i != REG_ZERO)) begin
            hazard_o = rs_hit_s || rt_hit_s;
        end else begin
            hazard_o = 1'b0;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/freeze sequencing for the 5-stage pipeline.
// Controls are Mealy (current state + current inputs) for zero-cycle hazard
// response; state, counters and the sticky watchdog error are registered.
// Optional feature macro: PIPE_HAZARD_CTRL_PERF_EN adds stall/flush counters.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int INIT_CYCLES = 2,   // 1..15 post-reset clearing cycles
    parameter int MEM_TIMEOUT = 255  // 0 disables the memory-wait watchdog
) (
    input  logic              clk_i,
    input  logic              rst_i,
    pipe_hazard_ctrl_if.slave hz
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    ,
    output logic [PERF_CNT_W-1:0] stall_cnt_o,
    output logic [PERF_CNT_W-1:0] flush_cnt_o
`endif
);

    localparam logic [INIT_CNT_W-1:0] INIT_LAST = INIT_CNT_W'(INIT_CYCLES - 1);
    localparam logic [WAIT_CNT_W-1:0] TIMEOUT_V = WAIT_CNT_W'(MEM_TIMEOUT);
    localparam logic                  WDOG_EN   = (MEM_TIMEOUT != 0);

    state_e                  state_q,    state_d;
    logic [INIT_CNT_W-1:0]   init_cnt_q, init_cnt_d;
    logic [WAIT_CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                    err_q,      err_d;

    logic                    ldu_hazard_s;
    logic [WAIT_CNT_W-1:0]   wait_inc_s;
    logic                    wdog_hit_s;
    ctrl_t                   fsm_ctrl_s;
    ctrl_t                   ctrl_s;

    pipe_hazard_ctrl_ldu u_ldu (
        .id_rs_i       (hz.ID_rs_i),
        .id_rt_i       (hz.ID_rt_i),
        .ex_mem_read_i (hz.EX_MemRead_i),
        .ex_rt_i       (hz.EX_rt_i),
        .hazard_o      (ldu_hazard_s)
    );

    // Watchdog: the wait counter reaches the limit on this edge
    always_comb begin
        wait_inc_s = wait_inc(wait_cnt_q);
        if (WDOG_EN) begin
            wdog_hit_s = (wait_inc_s == TIMEOUT_V);
        end else begin
            wdog_hit_s = 1'b0;
        end
    end

    // Next-state, counter and control decode for the current cycle
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        wait_cnt_d = wait_cnt_q;
        err_d      = err_q;
        fsm_ctrl_s = CTRL_RESET;
        case (state_q)
            INIT: begin
                fsm_ctrl_s = CTRL_RESET;
                if (init_cnt_q == INIT_LAST) begin
                    state_d    = RUN;
                    init_cnt_d = {INIT_CNT_W{1'b0}};
                end else begin
                    init_cnt_d = init_cnt_q + 4'd1;
                end
            end
            RUN: begin
                if (hz.dmem_miss_i) begin
                    fsm_ctrl_s = CTRL_FREEZE;
                    state_d    = MEM_WAIT;
                    wait_cnt_d = {WAIT_CNT_W{1'b0}};
                end else begin
                    fsm_ctrl_s = run_ctrl(ldu_hazard_s, hz.ID_taken_i);
                end
            end
            MEM_WAIT: begin
                if (hz.dmem_ack_i) begin
                    // Access completes: release now; a fresh miss is not
                    // looked at until the next cycle.
                    fsm_ctrl_s = run_ctrl(ldu_hazard_s, hz.ID_taken_i);
                    state_d    = RUN;
                end else begin
                    fsm_ctrl_s = CTRL_FREEZE;
                    wait_cnt_d = wait_inc_s;
                    if (wdog_hit_s) begin
                        err_d   = 1'b1;
                        state_d = RUN;
                    end else begin
                        state_d = MEM_WAIT;
                    end
                end
            end
            default: begin
                fsm_ctrl_s = CTRL_RESET;
                state_d    = INIT;
                init_cnt_d = {INIT_CNT_W{1'b0}};
                wait_cnt_d = {WAIT_CNT_W{1'b0}};
            end
        endcase
    end

    // Reset overrides the controls in the same cycle it is asserted
    always_comb begin
        if (rst_i) begin
            ctrl_s = CTRL_RESET;
        end else begin
            ctrl_s = fsm_ctrl_s;
        end
    end

    // FSM state, counters and sticky error
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= INIT;
            init_cnt_q <= {INIT_CNT_W{1'b0}};
            wait_cnt_q <= {WAIT_CNT_W{1'b0}};
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    assign hz.PC_write_o    = ctrl_s.pc_write;
    assign hz.IF_ID_Stall_o = ctrl_s.if_id_stall;
    assign hz.IF_ID_Flush_o = ctrl_s.if_id_flush;
    assign hz.ID_EX_Flush_o = ctrl_s.id_ex_flush;
    assign hz.Freeze_o      = ctrl_s.freeze;
    assign hz.err_o         = err_q;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [PERF_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [PERF_CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Count stall cycles, and flush cycles outside the post-reset window
    // (the ack cycle of MEM_WAIT decodes as RUN and is counted too)
    always_comb begin
        stall_cnt_d = perf_inc(stall_cnt_q, ctrl_s.if_id_stall);
        flush_cnt_d = perf_inc(flush_cnt_q, ctrl_s.if_id_flush && (state_q != INIT));
    end

    // Performance counter registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= {PERF_CNT_W{1'b0}};
            flush_cnt_q <= {PERF_CNT_W{1'b0}};
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: table vectors, directed multi-cycle sequences and
// randomized stimulus against a behavioural model of the hazard rules.
// Build with PIPE_HAZARD_CTRL_PERF_EN to include the perf counters.
module tb_pipe_hazard_ctrl;

    localparam int INIT_CYCLES = 2;
    localparam int MEM_TIMEOUT = 8;

    typedef struct packed {
        logic pc;
        logic stall;
        logic iflush;
        logic eflush;
        logic freeze;
        logic err;
    } ctl_t;

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       memread;
        logic [4:0] ex_rt;
        logic       taken;
        logic       miss;
        logic       ack;
        ctl_t       exp;
    } vec_t;

    logic clk_i = 1'b0;
    logic rst_i;
    pipe_hazard_ctrl_if hz();
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [31:0] stall_cnt_o;
    logic [31:0] flush_cnt_o;
`endif

    pipe_hazard_ctrl #(
        .INIT_CYCLES (INIT_CYCLES),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .hz          (hz)
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        ,
        .stall_cnt_o (stall_cnt_o),
        .flush_cnt_o (flush_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Behavioural model: cycles since reset release, whether a memory
    // access is outstanding and for how long, sticky error, event counts.
    int          since_rel = 0;
    bit          waiting   = 1'b0;
    int          waited    = 0;
    bit          err_m     = 1'b0;
    logic [31:0] m_stall   = 32'd0;
    logic [31:0] m_flush   = 32'd0;

    ctl_t C_N, C_S, C_B, C_F, C_R;
    vec_t vecs[15];

    function automatic ctl_t mk(input logic pc, input logic st, input logic fl,
                                input logic ef, input logic fz, input logic er);
        ctl_t c;
        c.pc = pc; c.stall = st; c.iflush = fl; c.eflush = ef; c.freeze = fz; c.err = er;
        return c;
    endfunction

    function automatic vec_t mkv(input int rs, input int rt, input bit mr, input int ert,
                                 input bit tk, input bit ms, input bit ak, input ctl_t e);
        vec_t v;
        v.rs = 5'(rs); v.rt = 5'(rt); v.memread = mr; v.ex_rt = 5'(ert);
        v.taken = tk; v.miss = ms; v.ack = ak; v.exp = e;
        return v;
    endfunction

    function automatic ctl_t model_ctl();
        bit hazard;
        ctl_t e;
        hazard = hz.EX_MemRead_i && (hz.EX_rt_i != 5'd0) &&
                 ((hz.EX_rt_i == hz.ID_rs_i) || (hz.EX_rt_i == hz.ID_rt_i));
        if (rst_i || since_rel < INIT_CYCLES)         e = mk(0, 0, 1, 1, 0, err_m);
        else if (waiting && !hz.dmem_ack_i)           e = mk(0, 1, 0, 0, 1, err_m);
        else if (!waiting && hz.dmem_miss_i)          e = mk(0, 1, 0, 0, 1, err_m);
        else if (hazard)                              e = mk(0, 1, 0, 1, 0, err_m);
        else if (hz.ID_taken_i)                       e = mk(1, 0, 1, 0, 0, err_m);
        else                                          e = mk(1, 0, 0, 0, 0, err_m);
        return e;
    endfunction

    task automatic model_advance(input ctl_t e);
        if (rst_i) begin
            since_rel = 0; waiting = 1'b0; waited = 0; err_m = 1'b0;
            m_stall = 32'd0; m_flush = 32'd0;
        end else begin
            if (e.stall && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
            if (e.iflush && since_rel >= INIT_CYCLES && m_flush != 32'hFFFF_FFFF)
                m_flush = m_flush + 32'd1;
            if (since_rel < INIT_CYCLES) begin
                since_rel++;
            end else if (waiting) begin
                if (hz.dmem_ack_i) begin
                    waiting = 1'b0;
                end else begin
                    waited = (waited < 255) ? waited + 1 : 255;
                    if (MEM_TIMEOUT != 0 && waited == MEM_TIMEOUT) begin
                        err_m = 1'b1;
                        waiting = 1'b0;
                    end
                end
            end else if (hz.dmem_miss_i) begin
                waiting = 1'b1;
                waited = 0;
            end
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_ctl(input string tag, input ctl_t act, input ctl_t exp);
        check1({tag, ".PC_write"},    act.pc,     exp.pc);
        check1({tag, ".IF_ID_Stall"}, act.stall,  exp.stall);
        check1({tag, ".IF_ID_Flush"}, act.iflush, exp.iflush);
        check1({tag, ".ID_EX_Flush"}, act.eflush, exp.eflush);
        check1({tag, ".Freeze"},      act.freeze, exp.freeze);
        check1({tag, ".err"},         act.err,    exp.err);
    endtask

    // One clock: compare at the falling edge, then advance the model
    task automatic step(input string tag, input bit has_exp, input ctl_t want);
        ctl_t act;
        ctl_t m;
        @(negedge clk_i);
        act = mk(hz.PC_write_o, hz.IF_ID_Stall_o, hz.IF_ID_Flush_o,
                 hz.ID_EX_Flush_o, hz.Freeze_o, hz.err_o);
        m = model_ctl();
        cmp_ctl({tag, "/model"}, act, m);
        if (has_exp) cmp_ctl({tag, "/exp"}, act, want);
        check1({tag, "/inv_stall_flush"}, act.stall & act.iflush, 1'b0);
        check1({tag, "/inv_pc_stall"}, act.stall & act.pc, 1'b0);
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        check32({tag, "/stall_cnt"}, stall_cnt_o, m_stall);
        check32({tag, "/flush_cnt"}, flush_cnt_o, m_flush);
`endif
        model_advance(m);
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input int rs, input int rt, input bit mr, input int ert,
                         input bit tk, input bit ms, input bit ak);
        hz.ID_rs_i = 5'(rs); hz.ID_rt_i = 5'(rt); hz.EX_MemRead_i = mr;
        hz.EX_rt_i = 5'(ert); hz.ID_taken_i = tk; hz.dmem_miss_i = ms; hz.dmem_ack_i = ak;
    endtask

    task automatic idle();
        drive(0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        ctl_t w;
        C_N = mk(1, 0, 0, 0, 0, 0);
        C_S = mk(0, 1, 0, 1, 0, 0);
        C_B = mk(1, 0, 1, 0, 0, 0);
        C_F = mk(0, 1, 0, 0, 1, 0);
        C_R = mk(0, 0, 1, 1, 0, 0);

        //              rs rt mr ert tk ms ak  expected
        vecs[0]  = mkv(0, 0, 0, 0, 0, 0, 0, C_N);
        vecs[1]  = mkv(5, 0, 1, 5, 0, 0, 0, C_S);   // rs load-use
        vecs[2]  = mkv(5, 0, 0, 5, 0, 0, 0, C_N);   // load moved on
        vecs[3]  = mkv(1, 7, 1, 7, 0, 0, 0, C_S);   // rt load-use
        vecs[4]  = mkv(0, 0, 1, 0, 0, 0, 0, C_N);   // r0 never hazards
        vecs[5]  = mkv(3, 4, 1, 9, 0, 0, 0, C_N);   // no match
        vecs[6]  = mkv(0, 0, 0, 0, 1, 0, 0, C_B);   // taken branch
        vecs[7]  = mkv(6, 0, 1, 6, 1, 0, 0, C_S);   // hazard beats branch
        vecs[8]  = mkv(0, 0, 0, 0, 0, 0, 1, C_N);   // ack ignored in RUN
        vecs[9]  = mkv(0, 0, 0, 0, 1, 1, 0, C_F);   // miss beats branch
        vecs[10] = mkv(0, 0, 0, 0, 1, 1, 1, C_B);   // ack: miss ignored
        vecs[11] = mkv(0, 0, 0, 0, 0, 0, 0, C_N);
        vecs[12] = mkv(2, 0, 1, 2, 0, 1, 0, C_F);   // miss beats hazard
        vecs[13] = mkv(2, 0, 1, 2, 0, 0, 1, C_S);   // ack releases into stall
        vecs[14] = mkv(0, 0, 0, 0, 0, 0, 0, C_N);

        idle();
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;

        // Reset window: 3 cycles of reset, 2 clearing cycles, then run
        for (int i = 0; i < 3; i++) step("rst_hold", 1'b1, C_R);
        rst_i = 1'b0;
        for (int i = 0; i < 2; i++) step("init_win", 1'b1, C_R);
        step("first_run", 1'b1, C_N);

        // Table vectors, one cycle each
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].rs, vecs[i].rt, vecs[i].memread, vecs[i].ex_rt,
                  vecs[i].taken, vecs[i].miss, vecs[i].ack);
            step($sformatf("vec%0d", i), 1'b1, vecs[i].exp);
        end

        // Miss at t, ack at t+4, hazard visible but suppressed at t+2
        drive(0, 0, 0, 0, 0, 1, 0); step("mr_t0", 1'b1, C_F);
        idle();                     step("mr_t1", 1'b1, C_F);
        drive(4, 0, 1, 4, 0, 0, 0); step("mr_t2", 1'b1, C_F);
        idle();                     step("mr_t3", 1'b1, C_F);
        drive(4, 0, 1, 4, 0, 1, 1); step("mr_t4", 1'b1, C_S);
        idle();                     step("mr_t5", 1'b1, C_N);

        // Watchdog: miss, then 8 wait cycles with no ack
        drive(0, 0, 0, 0, 0, 1, 0); step("wd_miss", 1'b1, C_F);
        idle();
        for (int i = 0; i < MEM_TIMEOUT; i++) step("wd_wait", 1'b1, C_F);
        w = C_N; w.err = 1'b1;
        step("wd_err0", 1'b1, w);
        drive(0, 0, 0, 0, 0, 0, 1); step("wd_err1", 1'b1, w);
        idle();                     step("wd_err2", 1'b1, w);
        rst_i = 1'b1;
        w = C_R; w.err = 1'b1;
        step("wd_rst", 1'b1, w);
        rst_i = 1'b0;
        step("wd_clr0", 1'b1, C_R);
        step("wd_clr1", 1'b1, C_R);
        step("wd_clr2", 1'b1, C_N);

        // Reset in the middle of a memory wait aborts it
        drive(0, 0, 0, 0, 0, 1, 0); step("ab_miss", 1'b1, C_F);
        idle();                     step("ab_w1", 1'b1, C_F);
        step("ab_w2", 1'b1, C_F);
        rst_i = 1'b1;               step("ab_rst", 1'b1, C_R);
        rst_i = 1'b0;               step("ab_init0", 1'b1, C_R);
        step("ab_init1", 1'b1, C_R);
        step("ab_run", 1'b1, C_N);

        // Three load-use stalls and two taken branches since the reset above
        for (int i = 0; i < 3; i++) begin
            drive(i + 1, 0, 1, i + 1, 0, 0, 0); step("pf_stall", 1'b1, C_S);
            idle();                             step("pf_idle", 1'b1, C_N);
        end
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 0, 1, 0, 0); step("pf_br", 1'b1, C_B);
            idle();                     step("pf_idle", 1'b1, C_N);
        end
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        check32("perf_stall_total", stall_cnt_o, 32'd3);
        check32("perf_flush_total", flush_cnt_o, 32'd2);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            drive($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3), 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 9) < 3));
            rst_i = ($urandom_range(0, 63) == 0);
            step("rnd", 1'b0, C_N);
        end
        rst_i = 1'b0;
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage CPU. It generates the stall, flush and freeze controls for the PC, IF_ID, ID_EX and downstream pipeline registers. Its inputs are:
- load-use hazards detected in ID;
- branches and jumps taken in ID;
- data-memory misses signalled by MEM.

It also runs a post-reset pipeline-clearing window and a memory-wait watchdog.

## Interface
- INIT_CYCLES, 2: cycles after reset release during which the pipeline is flushed and the PC is held; range 1..15.
- MEM_TIMEOUT, 255: maximum number of MEM_WAIT cycles before `err_o`; 0 disables the watchdog; range 0..255.
- clk_i  in  1  clock; all state changes on its rising edge.
- rst_i  in  1  synchronous, active-high reset.
- ID_rs_i  in  5  rs field of the instruction in ID.
- ID_rt_i  in  5  rt field of the instruction in ID.
- EX_MemRead_i  in  1  the instruction in EX is a load.
- EX_rt_i  in  5  destination register of the load in EX.
- ID_taken_i  in  1  branch or jump resolved taken in ID.
- dmem_miss_i  in  1  MEM-stage access cannot complete this cycle.
- dmem_ack_i  in  1  the outstanding MEM access completes this cycle.
- PC_write_o  out  1  PC update enable.
- IF_ID_Stall_o  out  1  hold IF_ID.
- IF_ID_Flush_o  out  1  zero IF_ID.
- ID_EX_Flush_o  out  1  insert a bubble into ID_EX.
- Freeze_o  out  1  hold ID_EX, EX_MEM and MEM_WB.
- err_o  out  1  sticky watchdog error.
- stall_cnt_o  out  32  number of stall cycles; present only with `PIPE_HAZARD_CTRL_PERF_EN`.
- flush_cnt_o  out  32  number of flush cycles; present only with `PIPE_HAZARD_CTRL_PERF_EN`.

## Operation
- FSM states: INIT, RUN, MEM_WAIT.
- rst_i=1 forces:
  - state INIT, init counter 0, wait counter 0, err_o=0, perf counters 0;
  - outputs PC_write_o=0, IF_ID_Flush_o=1, ID_EX_Flush_o=1, IF_ID_Stall_o=0, Freeze_o=0.
- INIT: the reset outputs stay as above. The state advances to RUN after INIT_CYCLES cycles with rst_i=0.
- RUN. Conditions are evaluated in priority order, and the first match applies:
  1. **Memory miss** (dmem_miss_i=1): Freeze_o=1, IF_ID_Stall_o=1, PC_write_o=0, all flushes 0. Next state MEM_WAIT; the wait counter is cleared.
  2. **Load-use hazard** (EX_MemRead_i && EX_rt_i!=0 && (EX_rt_i==ID_rs_i || EX_rt_i==ID_rt_i)): PC_write_o=0, IF_ID_Stall_o=1, ID_EX_Flush_o=1. ID_taken_i is ignored because the branch operands are not yet valid.
  3. **Taken branch** (ID_taken_i=1): IF_ID_Flush_o=1, PC_write_o=1.
  4. **Otherwise**: PC_write_o=1, all other controls 0.
- MEM_WAIT:
  - While dmem_ack_i=0: the freeze outputs of the memory-miss case are held and the wait counter increments, saturating at 255.
  - When dmem_ack_i=1: the outputs are released in that same cycle and evaluated exactly as in RUN, except that dmem_miss_i is ignored in that cycle. Next state RUN.
  - If MEM_TIMEOUT!=0 and the wait counter reaches MEM_TIMEOUT: err_o is set and the next state is RUN.
- err_o is sticky and is cleared only by rst_i.
- dmem_ack_i is ignored in RUN and INIT.
- **Invariants**, asserted in the bench:
  - IF_ID_Stall_o and IF_ID_Flush_o are never both 1.
  - PC_write_o=0 whenever IF_ID_Stall_o=1.

## Timing
- All outputs are combinational from the current state and current inputs (Mealy), so hazard response has zero-cycle latency.
- State, counters and err_o are registered.
- A load-use stall lasts exactly one cycle, because the load advances to MEM and clears the hazard.
- A miss at cycle t with an ack at cycle t+n gives Freeze_o=1 for cycles t..t+n-1 and 0 at cycle t+n.
- rst_i asserted mid-MEM_WAIT aborts the wait on the next edge. The MEM side must drop the outstanding access on reset.

## Configuration
- `PIPE_HAZARD_CTRL_PERF_EN` defined:
  - stall_cnt_o increments in every cycle with IF_ID_Stall_o=1;
  - flush_cnt_o increments in every cycle with IF_ID_Flush_o=1 in RUN;
  - both saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: the counters and both ports are absent, and behaviour is otherwise identical.

## Structure
- `pipe_hazard_ctrl_pkg` holds:
  - the state encoding (INIT=2'd0, RUN=2'd1, MEM_WAIT=2'd2);
  - REG_ZERO=5'd0;
  - the counter widths.
- Sub-module `pipe_hazard_ctrl_ldu`: combinational load-use comparator. It takes ID_rs, ID_rt, EX_MemRead and EX_rt, and produces the hazard bit.

## Test plan
- **Reset window**: rst_i high 3 cycles, then low → PC_write_o=0 and IF_ID_Flush_o=1 for 2 cycles, then PC_write_o=1 with all controls 0.
- **Load-use detection**: EX_MemRead_i=1, EX_rt_i=5, ID_rs_i=5 → one cycle of IF_ID_Stall_o=1, ID_EX_Flush_o=1, PC_write_o=0. Repeat with EX_rt_i=0 → no stall.
- **Branch vs load-use priority**: ID_taken_i=1 alone → IF_ID_Flush_o=1 for 1 cycle. Same cycle as a load-use hazard → stall only, IF_ID_Flush_o=0.
- **Memory miss and release**: miss at cycle 10, ack at cycle 14 → Freeze_o=1 in cycles 10-13, 0 in cycle 14. A hazard present in cycle 12 is suppressed, then acted on in cycle 14.
- **Watchdog and reset abort**: MEM_TIMEOUT=8, miss with no ack → err_o=1 after 8 wait cycles, state RUN, err_o stays 1 until rst_i. A separate run asserts rst_i mid-wait → INIT on the next edge.
- **Perf counters** (with `PIPE_HAZARD_CTRL_PERF_EN`): 3 load-use stalls plus 2 taken branches → stall_cnt_o=3, flush_cnt_o=2.
